// File: rtl/fifo_drain_pkg.sv
// Shared types and default sizing for the FIFO burst-drain controller.
// Optional DRAIN_CHECKSUM_EN adds a per-burst XOR checksum output on fifo_drain_ctrl.
package fifo_drain_pkg;

  localparam int unsigned DefaultDataW    = 8;
  localparam int unsigned DefaultBurstLen = 4;

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t IDLE  = 2'd0;
  localparam drain_state_t BURST = 2'd1;
  localparam drain_state_t DRAIN = 2'd2;
  localparam drain_state_t DONE  = 2'd3;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order holding buffer between the FIFO read port and the output register.
// Callers never push when full or pop when empty.
module drain_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] entry0_q, entry1_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) entry0_q <= push_data;
          else                 entry1_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          entry0_q <= entry1_q;
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            entry0_q <= push_data;
          end else begin
            entry0_q <= entry1_q;
            entry1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = entry0_q;
  assign count     = count_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream synchronous-read FIFO in bursts into a registered valid/ready output.
// Define DRAIN_CHECKSUM_EN to add burst_csum, the XOR of the words of the last burst.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned BURST_LEN = DefaultBurstLen
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_almostfull,
  output logic              fifo_r_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              burst_done,
  output logic [3:0]        burst_cnt,
  output logic              busy
`ifdef DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] burst_csum
`endif
);

  drain_state_t      state_q, state_d;
  logic [3:0]        reads_q, reads_d;
  logic              inflight_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        burst_cnt_q;

  logic              rd_en, out_free, out_load, skid_push, skid_pop;
  logic              enter_burst, enter_done;
  logic [1:0]        skid_count;
  logic [DATA_W-1:0] skid_head;
  logic [2:0]        pending;

  drain_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (skid_push),
    .pop      (skid_pop),
    .push_data(fifo_data),
    .head_data(skid_head),
    .count    (skid_count)
  );

  // Output path: the skid head has priority; an arriving word bypasses only an empty skid.
  always_comb begin
    out_free    = !out_valid_q || out_ready;
    skid_pop    = out_free && (skid_count != 2'd0);
    skid_push   = inflight_q && !(out_free && (skid_count == 2'd0));
    out_load    = out_free && ((skid_count != 2'd0) || inflight_q);
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = (skid_count != 2'd0) ? skid_head : fifo_data;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end

  // Words not yet in the output register must always fit in the skid.
  assign pending = {1'b0, skid_count} + {2'b00, inflight_q};
  assign rd_en   = (state_q == BURST) && !fifo_empty && (pending < 3'd2) &&
                   (reads_q < 4'(BURST_LEN));

  always_comb begin
    state_d = state_q;
    reads_d = reads_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (fifo_almostfull || flush)) begin
          state_d = BURST;
          reads_d = 4'd0;
        end
      end
      BURST: begin
        reads_d = reads_q + {3'b000, rd_en};
        if ((reads_d == 4'(BURST_LEN)) || (fifo_empty && (reads_q != 4'd0))) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && (skid_count == 2'd0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_burst = (state_q == IDLE) && (state_d == BURST);
  assign enter_done  = (state_q == DRAIN) && (state_d == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reads_q     <= 4'd0;
      inflight_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      reads_q     <= reads_d;
      inflight_q  <= rd_en;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      if (enter_done) burst_cnt_q <= reads_q;
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] csum_acc_q, csum_q;

  // Every word of a burst passes through the output register before DONE is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_acc_q <= '0;
      csum_q     <= '0;
    end else begin
      if (enter_burst)   csum_acc_q <= '0;
      else if (out_load) csum_acc_q <= csum_acc_q ^ out_data_d;
      if (enter_done)    csum_q     <= csum_acc_q;
    end
  end

  assign burst_csum = csum_q;
`endif

  assign fifo_r_en  = rd_en;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign burst_done = (state_q == DONE);
  assign burst_cnt  = burst_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl against a queue-based FIFO and burst model.
// Checksum checks are enabled when DRAIN_CHECKSUM_EN is defined.
module tb_fifo_drain_ctrl;

  localparam int AF  = 6;
  localparam int BL  = 4;

  logic       clk = 1'b0;
  logic       reset, flush, out_ready;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_almostfull = 1'b0;
  logic       fifo_r_en, out_valid, burst_done, busy;
  logic [7:0] out_data;
  logic [3:0] burst_cnt;
`ifdef DRAIN_CHECKSUM_EN
  logic [7:0] burst_csum;
  logic [7:0] done_csums[$];
`endif

  logic [7:0] fq[$];
  logic [7:0] got[$];
  logic [3:0] done_cnts[$];
  int         acc_cyc[$];
  int         cyc, issued, accepted, max_out, ren_empty_viol, stall_viol;
  int         first_ren, first_val, nchk, nerr;
  logic       stalled_prev, saw_busy;
  logic [7:0] held;

  fifo_drain_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_almostfull(fifo_almostfull),
    .fifo_r_en      (fifo_r_en),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .burst_done     (burst_done),
    .burst_cnt      (burst_cnt),
    .busy           (busy)
`ifdef DRAIN_CHECKSUM_EN
    ,
    .burst_csum     (burst_csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_mon();
    got.delete(); done_cnts.delete(); acc_cyc.delete();
`ifdef DRAIN_CHECKSUM_EN
    done_csums.delete();
`endif
    first_ren = -1; first_val = -1; max_out = 0; saw_busy = 1'b0;
  endtask

  // One clock: observe at the falling edge, then advance the FIFO model on the rising edge.
  task automatic step();
    int outst;
    @(negedge clk);
    cyc++;
    outst = issued - accepted - int'(out_valid);
    if (outst > max_out) max_out = outst;
    if (fifo_r_en) begin
      issued++;
      if (fifo_empty) ren_empty_viol++;
      if (first_ren < 0) first_ren = cyc;
    end
    if (out_valid && first_val < 0) first_val = cyc;
    if (stalled_prev && (!out_valid || out_data !== held)) stall_viol++;
    stalled_prev = out_valid && !out_ready;
    held = out_data;
    if (out_valid && out_ready) begin
      got.push_back(out_data); acc_cyc.push_back(cyc); accepted++;
    end
    if (busy) saw_busy = 1'b1;
    if (burst_done) begin
      done_cnts.push_back(burst_cnt);
`ifdef DRAIN_CHECKSUM_EN
      done_csums.push_back(burst_csum);
`endif
    end
    @(posedge clk);
    if (fifo_r_en && fq.size() != 0) fifo_data <= fq.pop_front();
    fifo_empty      <= (fq.size() == 0);
    fifo_almostfull <= (fq.size() >= AF);
    #2;
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    fifo_empty      <= 1'b0;
    fifo_almostfull <= (fq.size() >= AF);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    #1;
    nchk += 6;
    if (fifo_r_en !== 1'b0) begin nerr++; $display("FAIL rst_ren got %b exp 0", fifo_r_en); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    if (out_data !== 8'h00) begin nerr++; $display("FAIL rst_data got %h exp 00", out_data); end
    if (burst_done !== 1'b0) begin nerr++; $display("FAIL rst_done got %b exp 0", burst_done); end
    if (burst_cnt !== 4'd0) begin nerr++; $display("FAIL rst_cnt got %0d exp 0", burst_cnt); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", busy); end
    step();
    reset = 1'b0;
    step(); step();
    nchk++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_almostfull();
    logic [7:0] w[7] = '{8'd3, 8'd9, 8'd7, 8'd3, 8'd9, 8'd7, 8'd3};
    clear_mon();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) push_word(w[i]);
    for (int i = 0; i < 100 && !(done_cnts.size() >= 1 && got.size() >= 4); i++) step();
    for (int i = 0; i < 6; i++) step();
    nchk++;
    if (got.size() != 4) begin nerr++; $display("FAIL af_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      nchk++;
      if (got[i] !== w[i]) begin nerr++; $display("FAIL af_word%0d got %0d exp %0d", i, got[i], w[i]); end
    end
    nchk += 5;
    if (done_cnts.size() != 1) begin
      nerr++; $display("FAIL af_pulses got %0d exp 1", done_cnts.size());
    end else if (done_cnts[0] !== 4'd4) begin
      nerr++; $display("FAIL af_burst_cnt got %0d exp 4", done_cnts[0]);
    end
    if (first_val - first_ren != 2) begin
      nerr++; $display("FAIL af_latency got %0d exp 2", first_val - first_ren);
    end
    if (acc_cyc.size() < 4 || acc_cyc[3] - acc_cyc[0] != 3) begin
      nerr++; $display("FAIL af_throughput got %0d words not back-to-back exp 4 consecutive", acc_cyc.size());
    end
    if (busy !== 1'b0) begin nerr++; $display("FAIL af_idle_busy got %b exp 0", busy); end
    if (fq.size() != 3) begin nerr++; $display("FAIL af_left got %0d exp 3", fq.size()); end
  endtask

  task automatic test_flush();
    logic [7:0] w[3] = '{8'd9, 8'd7, 8'd3};
    clear_mon();
    ren_empty_viol = 0;
    flush = 1'b1;
    for (int i = 0; i < 100 && !(done_cnts.size() >= 1 && got.size() >= 3); i++) step();
    for (int i = 0; i < 6; i++) step();
    flush = 1'b0;
    nchk++;
    if (got.size() != 3) begin nerr++; $display("FAIL fl_count got %0d exp 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      nchk++;
      if (got[i] !== w[i]) begin nerr++; $display("FAIL fl_word%0d got %0d exp %0d", i, got[i], w[i]); end
    end
    nchk += 2;
    if (done_cnts.size() != 1) begin
      nerr++; $display("FAIL fl_pulses got %0d exp 1", done_cnts.size());
    end else if (done_cnts[0] !== 4'd3) begin
      nerr++; $display("FAIL fl_burst_cnt got %0d exp 3", done_cnts[0]);
    end
    if (ren_empty_viol != 0) begin
      nerr++; $display("FAIL fl_ren_empty got %0d exp 0", ren_empty_viol);
    end
  endtask

  task automatic test_stall();
    logic [7:0] w[4] = '{8'd3, 8'd9, 8'd7, 8'd3};
    logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_mon();
    stall_viol = 0;
    for (int i = 0; i < 4; i++) push_word(w[i]);
    flush = 1'b1;
    for (int i = 0; i < 200 && !(done_cnts.size() >= 1 && got.size() >= 4); i++) begin
      out_ready = pat[i % 4];
      step();
    end
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    nchk++;
    if (got.size() != 4) begin nerr++; $display("FAIL st_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      nchk++;
      if (got[i] !== w[i]) begin nerr++; $display("FAIL st_word%0d got %0d exp %0d", i, got[i], w[i]); end
    end
    nchk += 4;
    if (stall_viol != 0) begin nerr++; $display("FAIL st_hold got %0d exp 0", stall_viol); end
    if (max_out > 2) begin nerr++; $display("FAIL st_outstanding got %0d exp <=2", max_out); end
    if (!saw_busy) begin nerr++; $display("FAIL st_busy got 0 exp 1"); end
    if (done_cnts.size() != 1 || done_cnts[0] !== 4'd4) begin
      nerr++; $display("FAIL st_burst got %0d pulses exp 1 of cnt 4", done_cnts.size());
    end
`ifdef DRAIN_CHECKSUM_EN
    nchk++;
    if (done_csums.size() != 1 || done_csums[0] !== 8'h0E) begin
      nerr++; $display("FAIL st_csum got %0d entries exp one of 0E", done_csums.size());
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] exp_w[$];
    logic [7:0] csum;
    logic [3:0] exp_c;
    int         n, nb;
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      exp_w.delete();
      ren_empty_viol = 0; stall_viol = 0;
      n  = $urandom_range(1, 12);
      nb = (n + BL - 1) / BL;
      for (int i = 0; i < n; i++) begin
        exp_w.push_back(8'($urandom));
        push_word(exp_w[i]);
      end
      flush = 1'b1;
      for (int i = 0; i < 400 && !(got.size() >= n && done_cnts.size() >= nb); i++) begin
        out_ready = ($urandom % 4) != 0;
        step();
      end
      flush = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      nchk += 4;
      if (got.size() != n) begin nerr++; $display("FAIL rnd%0d_count got %0d exp %0d", it, got.size(), n); end
      if (done_cnts.size() != nb) begin
        nerr++; $display("FAIL rnd%0d_bursts got %0d exp %0d", it, done_cnts.size(), nb);
      end
      if (ren_empty_viol + stall_viol != 0) begin
        nerr++; $display("FAIL rnd%0d_proto got %0d exp 0", it, ren_empty_viol + stall_viol);
      end
      if (max_out > 2) begin nerr++; $display("FAIL rnd%0d_outstanding got %0d exp <=2", it, max_out); end
      for (int i = 0; i < n && i < got.size(); i++) begin
        nchk++;
        if (got[i] !== exp_w[i]) begin
          nerr++; $display("FAIL rnd%0d_word%0d got %h exp %h", it, i, got[i], exp_w[i]);
        end
      end
      for (int b = 0; b < nb && b < done_cnts.size(); b++) begin
        exp_c = 4'((n - b * BL) > BL ? BL : (n - b * BL));
        nchk++;
        if (done_cnts[b] !== exp_c) begin
          nerr++; $display("FAIL rnd%0d_cnt%0d got %0d exp %0d", it, b, done_cnts[b], exp_c);
        end
`ifdef DRAIN_CHECKSUM_EN
        csum = 8'h00;
        for (int k = b * BL; k < b * BL + int'(exp_c); k++) csum ^= exp_w[k];
        nchk++;
        if (b < done_csums.size() && done_csums[b] !== csum) begin
          nerr++; $display("FAIL rnd%0d_csum%0d got %h exp %h", it, b, done_csums[b], csum);
        end
`else
        csum = 8'h00;
`endif
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b1;
    push_word(8'd3); push_word(8'd9); push_word(8'd7); push_word(8'd3);
    flush = 1'b1;
    for (int i = 0; i < 100 && got.size() < 2; i++) step();
    reset = 1'b1;
    #1;
    nchk += 7;
    if (got.size() != 2 || got[0] !== 8'd3 || got[1] !== 8'd9) begin
      nerr++; $display("FAIL rm_pre got %0d words exp 3,9", got.size());
    end
    if (fifo_r_en !== 1'b0) begin nerr++; $display("FAIL rm_ren got %b exp 0", fifo_r_en); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rm_valid got %b exp 0", out_valid); end
    if (out_data !== 8'h00) begin nerr++; $display("FAIL rm_data got %h exp 00", out_data); end
    if (burst_done !== 1'b0) begin nerr++; $display("FAIL rm_done got %b exp 0", burst_done); end
    if (burst_cnt !== 4'd0) begin nerr++; $display("FAIL rm_cnt got %0d exp 0", burst_cnt); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL rm_busy got %b exp 0", busy); end
    fq.delete();
    fifo_empty <= 1'b1; fifo_almostfull <= 1'b0;
    flush = 1'b0;
    step();
    reset = 1'b0;
    issued = 0; accepted = 0; stalled_prev = 1'b0;
    step();
    nchk += 2;
    if (busy !== 1'b0) begin nerr++; $display("FAIL rm_idle got %b exp 0", busy); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL rm_valid_after got %b exp 0", out_valid); end
    for (int i = 0; i < 5; i++) step();
    nchk++;
    if (got.size() != 2) begin nerr++; $display("FAIL rm_discard got %0d exp 2", got.size()); end
  endtask

  initial begin
    nchk = 0; nerr = 0; cyc = 0; issued = 0; accepted = 0;
    ren_empty_viol = 0; stall_viol = 0; stalled_prev = 1'b0; held = 8'h00;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    clear_mon();
    test_reset();
    test_almostfull();
    test_flush();
    test_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FIFO word width.
REQ-002 SHALL have parameter BURST_LEN, default 4, max words per burst (range 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  level; drain whatever the FIFO holds even below almostfull.
REQ-006 SHALL have port fifo_data  input  DATA_W  upstream sync_fifo data_out.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_almostfull  input  1  upstream FIFO almostfull flag.
REQ-009 SHALL have port fifo_r_en  output  1  read enable to upstream FIFO r_en.
REQ-010 SHALL have port out_data  output  DATA_W  downstream word.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 SHALL have port burst_done  output  1  one-cycle pulse at end of each burst.
REQ-014 SHALL have port burst_cnt  output  4  words read in last completed burst.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL treat upstream FIFO as synchronous read: fifo_data valid the cycle after fifo_r_en sampled high.
REQ-017 SHALL implement FSM IDLE -> BURST -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE -> BURST when fifo_empty=0 and (fifo_almostfull=1 or flush=1).
REQ-019 In BURST SHALL assert fifo_r_en only when fifo_empty=0 and (skid occupancy + in-flight read) < 2.
REQ-020 SHALL never assert fifo_r_en when fifo_empty=1 or outside BURST.
REQ-021 BURST -> DRAIN after BURST_LEN reads issued, or when fifo_empty=1 with at least one read issued.
REQ-022 DRAIN -> DONE when no read in flight and skid buffer empty; DONE lasts exactly one cycle with burst_done=1, then IDLE.
REQ-023 burst_cnt SHALL update in DONE to reads issued in that burst; hold otherwise.
REQ-024 out_data/out_valid SHALL be registered; once out_valid=1, out_data SHALL hold stable until accepted.
REQ-025 Words SHALL leave in FIFO read order; none dropped or duplicated under any out_ready pattern.
REQ-026 With out_ready held 1, sustained throughput SHALL be one word per cycle; first out_valid two cycles after first fifo_r_en.
REQ-027 flush deasserting mid-burst SHALL NOT abort the burst.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, fifo_r_en=0, out_valid=0, out_data=0, burst_done=0, burst_cnt=0, busy=0, skid empty, in-flight flag clear.
REQ-029 Reset mid-burst SHALL discard buffered and in-flight words; first cycle after release is IDLE.

Configuration
REQ-030 With DRAIN_CHECKSUM_EN defined, SHALL add output burst_csum (DATA_W) = XOR of all words delivered in the burst, updated in DONE, reset to 0.
REQ-031 Without DRAIN_CHECKSUM_EN, port burst_csum and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package fifo_drain_pkg SHALL hold FSM state typedef (IDLE, BURST, DRAIN, DONE) and default DATA_W/BURST_LEN constants.
REQ-033 2-entry output buffer SHALL be sub-module drain_skid_buf (push, pop, count, DATA_W data).

Verification
REQ-034 Write 7 words (3,9,7,3,9,7,3) into FIFO, out_ready=1 -> almostfull triggers burst; outputs 3,9,7,3; burst_done pulse, burst_cnt=4.
REQ-035 3 words in FIFO, flush=1 -> one burst of 3, burst_cnt=3, fifo_r_en never high while fifo_empty=1.
REQ-036 out_ready toggled 1,0,0,1 repeatedly during burst -> out_data stable while stalled, order 3,9,7,3 preserved, no more than 2 reads outstanding.
REQ-037 reset pulsed for 1 cycle after 2nd word delivered -> all outputs at reset values immediately, FSM in IDLE next cycle.
REQ-038 DRAIN_CHECKSUM_EN defined, burst 3,9,7,3 -> burst_csum=8'h0E at burst_done.
